// File: rtl/sc_ulpi_reg_engine.sv
// Link-side ULPI register access engine: sequences TX CMD / extended address / data / STP
// and read turnaround, retries PHY aborts, times out hung accesses, and monitors RX CMDs.
module sc_ulpi_reg_engine #(
  parameter bit EXT_ADDR_EN = 1'b1,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ULPI_DIR,
  input  logic       ULPI_NXT,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE,
  output logic       ULPI_STP,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WRITE,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       RSP_ERR,
  output logic [7:0] RXCMD,
  output logic       RXCMD_VALID
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_EADR, S_WDATA, S_STP, S_RTURN,
    S_RDATA, S_RESP, S_ABORT, S_TOSTP, S_ERRW
  } state_t;

  state_t         state_reg;
  logic           dir_q;
  logic [7:0]     data_o_reg;
  logic           stp_reg;
  logic           ready_reg;
  logic           rsp_valid_reg;
  logic [7:0]     rsp_rdata_reg;
  logic           rsp_err_reg;
  logic [7:0]     rxcmd_reg;
  logic           rxcmd_valid_reg;
  logic           wr_reg;
  logic           ext_reg;
  logic [7:0]     addr_reg;
  logic [7:0]     wdata_reg;
  logic [RW-1:0]  retry_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           low_cnt;

  logic           req_ext;
  logic [7:0]     req_txcmd;
  logic [7:0]     txcmd;
  logic           tmo_hit;
  logic           retry_last;

  // Addresses above the immediate range are reached through the 0x2F escape.
  assign req_ext    = (REQ_ADDR > 8'h2E);
  assign req_txcmd  = {1'b1, ~REQ_WRITE, req_ext ? 6'h2F : REQ_ADDR[5:0]};
  assign txcmd      = {1'b1, ~wr_reg, ext_reg ? 6'h2F : addr_reg[5:0]};
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
  assign retry_last = (retry_cnt >= RW'(MAX_RETRY));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg       <= S_IDLE;
      dir_q           <= 1'b1;
      data_o_reg      <= 8'h00;
      stp_reg         <= 1'b0;
      ready_reg       <= 1'b1;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= 8'h00;
      rsp_err_reg     <= 1'b0;
      rxcmd_reg       <= 8'h00;
      rxcmd_valid_reg <= 1'b0;
      wr_reg          <= 1'b0;
      ext_reg         <= 1'b0;
      addr_reg        <= 8'h00;
      wdata_reg       <= 8'h00;
      retry_cnt       <= '0;
      tmo_cnt         <= '0;
      low_cnt         <= 1'b0;
    end else begin
      dir_q           <= ULPI_DIR;
      rxcmd_valid_reg <= 1'b0;
      // RX CMDs arrive with NXT low once the PHY owns the bus; read data is not an RX CMD.
      if (ULPI_DIR && dir_q && !ULPI_NXT && state_reg != S_RDATA) begin
        rxcmd_reg       <= ULPI_DATA_I;
        rxcmd_valid_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          data_o_reg <= 8'h00;
          if (REQ_VALID && ready_reg) begin
            ready_reg <= 1'b0;
            wr_reg    <= REQ_WRITE;
            ext_reg   <= req_ext;
            addr_reg  <= REQ_ADDR;
            wdata_reg <= REQ_WDATA;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            if (!EXT_ADDR_EN && req_ext) begin
              state_reg <= S_ERRW;
            end else begin
              state_reg  <= S_CMD;
              data_o_reg <= req_txcmd;
            end
          end else begin
            ready_reg <= ~ULPI_DIR;
          end
        end

        S_CMD, S_EADR, S_WDATA: begin
          if (ULPI_DIR) begin
            data_o_reg <= 8'h00;
            tmo_cnt    <= '0;
            low_cnt    <= 1'b0;
            if (retry_last) begin
              state_reg     <= S_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= 8'h00;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state_reg <= S_ABORT;
            end
          end else if (ULPI_NXT) begin
            tmo_cnt <= '0;
            case (state_reg)
              S_CMD: begin
                if (ext_reg) begin
                  state_reg  <= S_EADR;
                  data_o_reg <= addr_reg;
                end else if (wr_reg) begin
                  state_reg  <= S_WDATA;
                  data_o_reg <= wdata_reg;
                end else begin
                  state_reg  <= S_RTURN;
                  data_o_reg <= 8'h00;
                end
              end
              S_EADR: begin
                if (wr_reg) begin
                  state_reg  <= S_WDATA;
                  data_o_reg <= wdata_reg;
                end else begin
                  state_reg  <= S_RTURN;
                  data_o_reg <= 8'h00;
                end
              end
              default: begin
                state_reg  <= S_STP;
                stp_reg    <= 1'b1;
                data_o_reg <= 8'h00;
              end
            endcase
          end else if (tmo_hit) begin
            state_reg  <= S_TOSTP;
            stp_reg    <= 1'b1;
            data_o_reg <= 8'h00;
            tmo_cnt    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RTURN: begin
          if (ULPI_DIR) begin
            state_reg <= S_RDATA;
            tmo_cnt   <= '0;
          end else if (tmo_hit) begin
            state_reg <= S_TOSTP;
            stp_reg   <= 1'b1;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RDATA: begin
          state_reg     <= S_RESP;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= ULPI_DATA_I;
        end

        S_STP: begin
          stp_reg       <= 1'b0;
          state_reg     <= S_RESP;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= 8'h00;
        end

        S_TOSTP, S_ERRW: begin
          stp_reg       <= 1'b0;
          state_reg     <= S_RESP;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b1;
          rsp_rdata_reg <= 8'h00;
        end

        // PHY took the bus mid-command: re-issue only after two consecutive idle cycles.
        S_ABORT: begin
          if (ULPI_DIR) begin
            low_cnt <= 1'b0;
            if (tmo_hit) begin
              state_reg     <= S_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= 8'h00;
              tmo_cnt       <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end else if (low_cnt) begin
            low_cnt    <= 1'b0;
            state_reg  <= S_CMD;
            data_o_reg <= txcmd;
            tmo_cnt    <= '0;
          end else begin
            low_cnt <= 1'b1;
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RESP: begin
          rsp_valid_reg <= 1'b0;
          state_reg     <= S_IDLE;
          ready_reg     <= ~ULPI_DIR;
          tmo_cnt       <= '0;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign ULPI_DATA_O  = data_o_reg;
  assign ULPI_DATA_OE = ~ULPI_DIR & ~dir_q;
  assign ULPI_STP     = stp_reg;
  assign REQ_READY    = ready_reg;
  assign RSP_VALID    = rsp_valid_reg;
  assign RSP_RDATA    = rsp_rdata_reg;
  assign RSP_ERR      = rsp_err_reg;
  assign RXCMD        = rxcmd_reg;
  assign RXCMD_VALID  = rxcmd_valid_reg;

endmodule

// File: tb/tb_sc_ulpi_reg_engine.sv
// Directed bench for sc_ulpi_reg_engine: one instance with extended addressing, one without.
module tb_sc_ulpi_reg_engine;

  localparam int TMO = 255;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       DIR = 1'b0;
  logic       NXT = 1'b0;
  logic [7:0] DI = 8'h00;
  logic       REQ_VALID = 1'b0;
  logic       REQ_WRITE = 1'b0;
  logic [7:0] REQ_ADDR = 8'h00;
  logic [7:0] REQ_WDATA = 8'h00;

  logic [7:0] a_do, b_do, a_rdata, b_rdata, a_rxcmd, b_rxcmd;
  logic       a_oe, a_stp, a_ready, a_rspv, a_err, a_rxv;
  logic       b_oe, b_stp, b_ready, b_rspv, b_err, b_rxv;

  int total = 0;
  int bad = 0;

  sc_ulpi_reg_engine #(.EXT_ADDR_EN(1'b1), .MAX_RETRY(3), .TIMEOUT(TMO)) dut_a (
    .CLK(CLK), .RESET(RESET), .ULPI_DIR(DIR), .ULPI_NXT(NXT), .ULPI_DATA_I(DI),
    .ULPI_DATA_O(a_do), .ULPI_DATA_OE(a_oe), .ULPI_STP(a_stp),
    .REQ_VALID(REQ_VALID), .REQ_READY(a_ready), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(a_rspv), .RSP_RDATA(a_rdata), .RSP_ERR(a_err),
    .RXCMD(a_rxcmd), .RXCMD_VALID(a_rxv)
  );

  sc_ulpi_reg_engine #(.EXT_ADDR_EN(1'b0), .MAX_RETRY(3), .TIMEOUT(TMO)) dut_b (
    .CLK(CLK), .RESET(RESET), .ULPI_DIR(DIR), .ULPI_NXT(NXT), .ULPI_DATA_I(DI),
    .ULPI_DATA_O(b_do), .ULPI_DATA_OE(b_oe), .ULPI_STP(b_stp),
    .REQ_VALID(REQ_VALID), .REQ_READY(b_ready), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(b_rspv), .RSP_RDATA(b_rdata), .RSP_ERR(b_err),
    .RXCMD(b_rxcmd), .RXCMD_VALID(b_rxv)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  int stp_n, stp_cyc, rsp_cyc, rsp_cnt;
  logic seen, err_seen;

  initial begin
    // reset
    repeat (3) cyc();
    #1;
    check("rst_ready", a_ready, 1);
    check("rst_data", a_do, 8'h00);
    check("rst_stp", a_stp, 0);
    check("rst_oe", a_oe, 0);
    check("rst_rspv", a_rspv, 0);
    check("rst_rxv", a_rxv, 0);
    cyc(); RESET = 1'b0;
    cyc(); #1;
    check("idle_oe", a_oe, 1);
    check("idle_ready", a_ready, 1);

    // 1: write 0x0A <= 0x06
    REQ_VALID = 1; REQ_WRITE = 1; REQ_ADDR = 8'h0A; REQ_WDATA = 8'h06;
    cyc(); REQ_VALID = 0; #1;
    check("t1_cmd", a_do, 8'h8A);
    check("t1_ready_drop", a_ready, 0);
    check("t1_oe", a_oe, 1);
    cyc(); NXT = 1; #1;
    check("t1_cmd_hold", a_do, 8'h8A);
    cyc(); NXT = 0; #1;
    check("t1_wdata", a_do, 8'h06);
    cyc(); NXT = 1; #1;
    check("t1_wdata_hold", a_do, 8'h06);
    cyc(); NXT = 0; #1;
    check("t1_stp", a_stp, 1);
    check("t1_stp_data", a_do, 8'h00);
    cyc(); #1;
    check("t1_rspv", a_rspv, 1);
    check("t1_err", a_err, 0);
    check("t1_stp_end", a_stp, 0);
    cyc(); #1;
    check("t1_rsp_pulse", a_rspv, 0);
    check("t1_ready_back", a_ready, 1);
    $display("txn write 0x0A<=0x06 done");

    // 2: read 0x00, PHY returns 0x24
    REQ_VALID = 1; REQ_WRITE = 0; REQ_ADDR = 8'h00;
    cyc(); REQ_VALID = 0; NXT = 1; #1;
    check("t2_cmd", a_do, 8'hC0);
    cyc(); NXT = 0; DIR = 1; #1;
    check("t2_turn_oe", a_oe, 0);
    cyc(); DI = 8'h24; #1;
    cyc(); DIR = 0; DI = 8'h00; #1;
    check("t2_rspv", a_rspv, 1);
    check("t2_rdata", a_rdata, 8'h24);
    check("t2_err", a_err, 0);
    check("t2_no_rxv", a_rxv, 0);
    cyc(); #1;
    check("t2_no_rxv2", a_rxv, 0);
    check("t2_ready", a_ready, 1);
    $display("txn read 0x00 -> %0h", a_rdata);

    // 3: extended write 0x85 <= 0x11; second instance rejects it
    REQ_VALID = 1; REQ_WRITE = 1; REQ_ADDR = 8'h85; REQ_WDATA = 8'h11;
    cyc(); REQ_VALID = 0; NXT = 1; #1;
    check("t3_cmd", a_do, 8'hAF);
    check("t3b_bus_idle", b_do, 8'h00);
    check("t3b_no_rsp_yet", b_rspv, 0);
    cyc(); #1;
    check("t3_eadr", a_do, 8'h85);
    check("t3b_rspv", b_rspv, 1);
    check("t3b_err", b_err, 1);
    check("t3b_rdata", b_rdata, 8'h00);
    cyc(); #1;
    check("t3_wdata", a_do, 8'h11);
    check("t3b_bus_idle2", b_do, 8'h00);
    cyc(); NXT = 0; #1;
    check("t3_stp", a_stp, 1);
    check("t3b_no_stp", b_stp, 0);
    cyc(); #1;
    check("t3_rspv", a_rspv, 1);
    check("t3_err", a_err, 0);
    cyc(); #1;
    check("t3_ready", a_ready, 1);
    $display("txn ext write 0x85<=0x11 done");

    // 4: write 0x15 aborted by PHY RX CMDs until retries run out
    REQ_VALID = 1; REQ_WRITE = 1; REQ_ADDR = 8'h15; REQ_WDATA = 8'h33;
    cyc(); REQ_VALID = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_cmd", a_do, 8'h95);
      DIR = 1; DI = 8'h4D;
      cyc(); #1;
      if (i < 3) begin
        cyc(); DIR = 0; #1;
        check("t4_rxv", a_rxv, 1);
        check("t4_rxcmd", a_rxcmd, 8'h4D);
        cyc();
        cyc();
      end else begin
        check("t4_rspv", a_rspv, 1);
        check("t4_err", a_err, 1);
        cyc(); DIR = 0; DI = 8'h00; #1;
        check("t4_held_off", a_ready, 0);
        check("t4_rsp_pulse", a_rspv, 0);
        cyc(); #1;
        check("t4_ready", a_ready, 1);
      end
    end
    $display("txn abort/retry write 0x15 err=1");

    // 5a: PHY never asserts NXT
    REQ_VALID = 1; REQ_WRITE = 1; REQ_ADDR = 8'h01; REQ_WDATA = 8'h00;
    cyc(); REQ_VALID = 0; #1;
    check("t5_cmd", a_do, 8'h81);
    stp_n = 0; stp_cyc = 0; rsp_cyc = 0; seen = 0; err_seen = 0;
    for (int k = 1; k <= 400 && !seen; k++) begin
      if (a_stp) begin stp_n++; stp_cyc = k; end
      if (a_rspv) begin rsp_cyc = k; err_seen = a_err; seen = 1; end
      cyc(); #1;
    end
    check("t5_stp_cycle", 16'(stp_cyc), 16'(TMO + 1));
    check("t5_stp_width", 16'(stp_n), 1);
    check("t5_rsp_cycle", 16'(rsp_cyc), 16'(TMO + 2));
    check("t5_err", err_seen, 1);
    check("t5_ready", a_ready, 1);
    $display("txn timeout write 0x01 rsp at cycle %0d", rsp_cyc);

    // 5b: reset in the middle of a read
    REQ_VALID = 1; REQ_WRITE = 0; REQ_ADDR = 8'h02;
    cyc(); REQ_VALID = 0; NXT = 1; #1;
    check("t5b_cmd", a_do, 8'hC2);
    cyc(); NXT = 0; RESET = 1; #1;
    check("t5b_rturn_data", a_do, 8'h00);
    cyc(); RESET = 0; #1;
    check("t5b_ready", a_ready, 1);
    check("t5b_stp", a_stp, 0);
    check("t5b_oe", a_oe, 0);
    check("t5b_data", a_do, 8'h00);
    rsp_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(); #1;
      if (a_rspv) rsp_cnt++;
    end
    check("t5b_no_rsp", 16'(rsp_cnt), 0);
    check("t5b_oe_back", a_oe, 1);
    $display("txn reset mid-read, responses=%0d", rsp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
